// File: rtl/accelerator_convolutional_fnn_pkg.sv
// Shared constants and types for the convolutional FNN accelerator.
// Holds the fixed system sizes, the kernel tap count, the convolution engine
// FSM state type and the padding-mode encodings.
package accelerator_convolutional_fnn_pkg;

    // System sizes shared across the accelerator.
    parameter int unsigned DATA_SIZE    = 64;
    parameter int unsigned CONTROL_SIZE = 64;
    parameter int unsigned X_SIZE       = 64;
    parameter int unsigned Y_SIZE       = 64;
    parameter int unsigned N_SIZE       = 64;
    parameter int unsigned W_SIZE       = 64;
    parameter int unsigned L_SIZE       = 64;
    parameter int unsigned R_SIZE       = 64;

    // Kernel taps of the 1-D convolution engine.
    parameter int unsigned K_SIZE       = 3;

    // Padding mode encodings.
    localparam logic MODE_VALID = 1'b0;
    localparam logic MODE_SAME  = 1'b1;

    typedef enum logic [2:0] {
        StIdle,
        StLoadW,
        StLoadX,
        StMac,
        StEmit
    } conv_state_t;

endpackage

// File: rtl/accelerator_convolutional_fnn_engine_mac.sv
// Registered multiply-accumulate for the convolution engine.
// Ports:
//   clk, rst : clock and synchronous active-high reset (clears acc to 0)
//   clr      : load acc with bias (takes priority over en)
//   en       : acc <= acc + low DATA_SIZE bits of a*b, wrapping
//   bias     : value loaded on clr
//   a, b     : multiplicand (weight) and multiplier (padded sample)
//   acc      : accumulator register
module accelerator_convolutional_fnn_engine_mac #(
    parameter int unsigned DATA_SIZE = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 en,
    input  logic [DATA_SIZE-1:0] bias,
    input  logic [DATA_SIZE-1:0] a,
    input  logic [DATA_SIZE-1:0] b,
    output logic [DATA_SIZE-1:0] acc
);
    import accelerator_convolutional_fnn_pkg::*;

    logic [DATA_SIZE-1:0] prod;
    logic [DATA_SIZE-1:0] acc_q;

    // Product evaluated at DATA_SIZE width keeps only the low bits.
    always_comb begin
        prod = a * b;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else if (clr) begin
            acc_q <= bias;
        end else if (en) begin
            acc_q <= acc_q + prod;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/accelerator_convolutional_fnn_engine.sv
// 1-D convolution engine: loads K_SIZE weights and X_SIZE samples, then emits
// bias + sum_k w[k]*xp(t+k) for every output index t, one tap per cycle.
// Ports:
//   CLK, RST        : clock, synchronous active-high reset
//   START           : start pulse, honoured only while idle
//   MODE            : 0 = VALID, 1 = SAME padding, sampled at START
//   B_IN            : bias, sampled at START
//   W_IN_ENABLE/W_IN/W_IN_READY : weight load handshake
//   X_IN_ENABLE/X_IN/X_IN_READY : sample load handshake
//   Y_OUT_ENABLE/Y_OUT/Y_INDEX  : output pulse, word and index (held between pulses)
//   READY           : high while idle
// Optional feature: define ACCELERATOR_CONVOLUTIONAL_FNN_RELU_EN to clamp
// negative outputs to zero.
module accelerator_convolutional_fnn_engine #(
    parameter int unsigned DATA_SIZE = accelerator_convolutional_fnn_pkg::DATA_SIZE,
    parameter int unsigned X_SIZE    = accelerator_convolutional_fnn_pkg::X_SIZE,
    parameter int unsigned K_SIZE    = accelerator_convolutional_fnn_pkg::K_SIZE
) (
    input  logic                                         CLK,
    input  logic                                         RST,
    input  logic                                         START,
    input  logic                                         MODE,
    input  logic [DATA_SIZE-1:0]                         B_IN,
    input  logic                                         W_IN_ENABLE,
    input  logic [DATA_SIZE-1:0]                         W_IN,
    output logic                                         W_IN_READY,
    input  logic                                         X_IN_ENABLE,
    input  logic [DATA_SIZE-1:0]                         X_IN,
    output logic                                         X_IN_READY,
    output logic                                         Y_OUT_ENABLE,
    output logic [DATA_SIZE-1:0]                         Y_OUT,
    output logic [((X_SIZE > 1) ? $clog2(X_SIZE) : 1)-1:0] Y_INDEX,
    output logic                                         READY
);
    import accelerator_convolutional_fnn_pkg::*;

    localparam int unsigned IW  = (X_SIZE > 1) ? $clog2(X_SIZE) : 1;
    localparam int unsigned KW  = (K_SIZE > 1) ? $clog2(K_SIZE) : 1;
    localparam int unsigned PW  = IW + 1;
    localparam int unsigned PAD = (K_SIZE - 1) / 2;

    generate
        if ((K_SIZE < 1) || (X_SIZE < K_SIZE)) begin : g_bad_size
            $error("accelerator_convolutional_fnn_engine: need 1 <= K_SIZE <= X_SIZE");
        end
    endgenerate

    conv_state_t state_q, state_d;

    logic                 mode_q;
    logic [DATA_SIZE-1:0] bias_q;
    logic [DATA_SIZE-1:0] w_q [K_SIZE];
    logic [DATA_SIZE-1:0] x_q [X_SIZE];
    logic [KW-1:0]        wcnt_q;
    logic [KW-1:0]        k_q;
    logic [IW-1:0]        xcnt_q;
    logic [IW-1:0]        t_q;
    logic [IW-1:0]        t_last;
    logic [IW-1:0]        y_index_q;
    logic [DATA_SIZE-1:0] y_out_q;
    logic [DATA_SIZE-1:0] y_emit;
    logic [DATA_SIZE-1:0] acc;
    logic [DATA_SIZE-1:0] xp;
    logic [PW-1:0]        tap_pos;
    logic [PW-1:0]        src_pos;
    logic                 w_last;
    logic                 x_last;
    logic                 k_last;
    logic                 mac_clr;
    logic                 mac_en;

    assign w_last = (wcnt_q == KW'(K_SIZE - 1));
    assign x_last = (xcnt_q == IW'(X_SIZE - 1));
    assign k_last = (k_q == KW'(K_SIZE - 1));
    assign t_last = (mode_q == MODE_SAME) ? IW'(X_SIZE - 1) : IW'(X_SIZE - K_SIZE);

    // Next state and handshake/strobe outputs.
    always_comb begin
        state_d      = state_q;
        READY        = 1'b0;
        W_IN_READY   = 1'b0;
        X_IN_READY   = 1'b0;
        Y_OUT_ENABLE = 1'b0;
        mac_clr      = 1'b0;
        mac_en       = 1'b0;
        unique case (state_q)
            StIdle: begin
                READY = 1'b1;
                if (START) begin
                    state_d = StLoadW;
                end
            end
            StLoadW: begin
                W_IN_READY = 1'b1;
                if (W_IN_ENABLE && w_last) begin
                    state_d = StLoadX;
                end
            end
            StLoadX: begin
                X_IN_READY = 1'b1;
                if (X_IN_ENABLE && x_last) begin
                    state_d = StMac;
                    mac_clr = 1'b1;
                end
            end
            StMac: begin
                mac_en = 1'b1;
                if (k_last) begin
                    state_d = StEmit;
                end
            end
            StEmit: begin
                Y_OUT_ENABLE = 1'b1;
                if (t_q == t_last) begin
                    state_d = StIdle;
                end else begin
                    state_d = StMac;
                    mac_clr = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Control registers and counters.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= StIdle;
            mode_q    <= MODE_VALID;
            bias_q    <= '0;
            wcnt_q    <= '0;
            xcnt_q    <= '0;
            k_q       <= '0;
            t_q       <= '0;
            y_out_q   <= '0;
            y_index_q <= '0;
        end else begin
            state_q <= state_d;
            if (READY && START) begin
                mode_q <= MODE;
                bias_q <= B_IN;
                wcnt_q <= '0;
                xcnt_q <= '0;
            end
            if (W_IN_READY && W_IN_ENABLE) begin
                wcnt_q <= w_last ? '0 : wcnt_q + KW'(1);
            end
            if (X_IN_READY && X_IN_ENABLE) begin
                xcnt_q <= x_last ? '0 : xcnt_q + IW'(1);
                if (x_last) begin
                    t_q <= '0;
                    k_q <= '0;
                end
            end
            if (mac_en) begin
                k_q <= k_last ? '0 : k_q + KW'(1);
            end
            if (Y_OUT_ENABLE) begin
                y_out_q   <= y_emit;
                y_index_q <= t_q;
                if (t_q != t_last) begin
                    t_q <= t_q + IW'(1);
                end
            end
        end
    end

    // Operand storage needs no reset: it is always rewritten before use.
    always_ff @(posedge CLK) begin
        if (W_IN_READY && W_IN_ENABLE) begin
            w_q[wcnt_q] <= W_IN;
        end
        if (X_IN_READY && X_IN_ENABLE) begin
            x_q[xcnt_q] <= X_IN;
        end
    end

    // Padded sample for tap k of output t; SAME shifts left by PAD and zero-fills.
    always_comb begin
        tap_pos = {1'b0, t_q} + PW'(k_q);
        src_pos = tap_pos - PW'(PAD);
        xp      = '0;
        if (mode_q == MODE_SAME) begin
            if ((tap_pos >= PW'(PAD)) && (src_pos < PW'(X_SIZE))) begin
                xp = x_q[src_pos[IW-1:0]];
            end
        end else if (tap_pos < PW'(X_SIZE)) begin
            xp = x_q[tap_pos[IW-1:0]];
        end
    end

    accelerator_convolutional_fnn_engine_mac #(
        .DATA_SIZE (DATA_SIZE)
    ) u_mac (
        .clk  (CLK),
        .rst  (RST),
        .clr  (mac_clr),
        .en   (mac_en),
        .bias (bias_q),
        .a    (w_q[k_q]),
        .b    (xp),
        .acc  (acc)
    );

`ifdef ACCELERATOR_CONVOLUTIONAL_FNN_RELU_EN
    assign y_emit = acc[DATA_SIZE-1] ? '0 : acc;
`else
    assign y_emit = acc;
`endif

    // Live value during the pulse, held copy afterwards.
    assign Y_OUT   = Y_OUT_ENABLE ? y_emit : y_out_q;
    assign Y_INDEX = Y_OUT_ENABLE ? t_q : y_index_q;

endmodule

// File: tb/tb_accelerator_convolutional_fnn_engine.sv
module tb_accelerator_convolutional_fnn_engine;

    localparam int D = 64;
    localparam int X = 8;
    localparam int K = 3;
    localparam int P = (K - 1) / 2;

    logic         clk = 1'b0;
    logic         RST = 1'b1;
    logic         START = 1'b0;
    logic         MODE = 1'b0;
    logic [D-1:0] B_IN = '0;
    logic         W_IN_ENABLE = 1'b0;
    logic [D-1:0] W_IN = '0;
    logic         W_IN_READY;
    logic         X_IN_ENABLE = 1'b0;
    logic [D-1:0] X_IN = '0;
    logic         X_IN_READY;
    logic         Y_OUT_ENABLE;
    logic [D-1:0] Y_OUT;
    logic [2:0]   Y_INDEX;
    logic         READY;

    int checks = 0;
    int passes = 0;

    logic [D-1:0] mw [K];
    logic [D-1:0] mx [X];
    logic [D-1:0] exp_y [$];

    always #5 clk = ~clk;

    accelerator_convolutional_fnn_engine #(
        .DATA_SIZE (D),
        .X_SIZE    (X),
        .K_SIZE    (K)
    ) dut (
        .CLK          (clk),
        .RST          (RST),
        .START        (START),
        .MODE         (MODE),
        .B_IN         (B_IN),
        .W_IN_ENABLE  (W_IN_ENABLE),
        .W_IN         (W_IN),
        .W_IN_READY   (W_IN_READY),
        .X_IN_ENABLE  (X_IN_ENABLE),
        .X_IN         (X_IN),
        .X_IN_READY   (X_IN_READY),
        .Y_OUT_ENABLE (Y_OUT_ENABLE),
        .Y_OUT        (Y_OUT),
        .Y_INDEX      (Y_INDEX),
        .READY        (READY)
    );

    // Reference: direct evaluation of the convolution sum with modular 64-bit math.
    task automatic build_expected(input bit mode, input logic [D-1:0] b);
        int n_out;
        exp_y.delete();
        n_out = mode ? X : X - K + 1;
        for (int t = 0; t < n_out; t++) begin
            logic [D-1:0] acc;
            acc = b;
            for (int k = 0; k < K; k++) begin
                int i;
                logic [D-1:0] s;
                i = mode ? t + k - P : t + k;
                s = (i < 0 || i >= X) ? '0 : mx[i];
                acc = acc + mw[k] * s;
            end
`ifdef ACCELERATOR_CONVOLUTIONAL_FNN_RELU_EN
            if (acc[D-1]) acc = '0;
`endif
            exp_y.push_back(acc);
        end
    endtask

    task automatic set_ramp_data(input logic [D-1:0] w0, input logic [D-1:0] w1,
                                 input logic [D-1:0] w2);
        mw[0] = w0; mw[1] = w1; mw[2] = w2;
        for (int i = 0; i < X; i++) mx[i] = D'(i + 1);
    endtask

    // Runs one job starting at the current negedge and checks it against exp_y.
    task automatic run_job(input string name, input bit mode, input logic [D-1:0] b,
                           input bit stall, input bit junk, input bit start_in_x,
                           input int rst_at);
        int  accepted, guard, n, pulses, exp_cnt;
        bit  rdy_ok;
        START = 1'b1; MODE = mode; B_IN = b;
        @(negedge clk);
        START = 1'b0; MODE = ~mode; B_IN = {$urandom, $urandom};
        rdy_ok = 1'b1; accepted = 0; guard = 0;
        while (accepted < K && guard < 200) begin
            W_IN = mw[accepted];
            W_IN_ENABLE = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            X_IN_ENABLE = junk ? 1'($urandom_range(0, 1)) : 1'b0;
            X_IN = {$urandom, $urandom};
            if (W_IN_READY !== 1'b1 || X_IN_READY !== 1'b0) rdy_ok = 1'b0;
            if (W_IN_ENABLE) accepted++;
            @(negedge clk); guard++;
        end
        W_IN_ENABLE = 1'b0; X_IN_ENABLE = 1'b0;
        accepted = 0;
        while (accepted < X && guard < 400) begin
            X_IN = mx[accepted];
            X_IN_ENABLE = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            W_IN_ENABLE = junk ? 1'($urandom_range(0, 1)) : 1'b0;
            W_IN = {$urandom, $urandom};
            START = (start_in_x && accepted == 2) ? 1'b1 : 1'b0;
            if (X_IN_READY !== 1'b1 || W_IN_READY !== 1'b0) rdy_ok = 1'b0;
            if (X_IN_ENABLE) accepted++;
            @(negedge clk); guard++;
        end
        X_IN_ENABLE = 1'b0; W_IN_ENABLE = 1'b0; START = 1'b0;
        checks++;
        if (!rdy_ok || guard >= 400) $display("FAIL %s load_ready: handshake ready wrong or load timed out", name);
        else passes++;

        exp_cnt = (rst_at > 0) ? rst_at / (K + 1) : exp_y.size();
        n = 1; pulses = 0;
        while (n <= (K + 1) * exp_y.size() + 2) begin
            RST = (rst_at == n);
            if (rst_at > 0 && n == rst_at + 1) begin
                checks++;
                if (READY !== 1'b1 || Y_OUT !== '0 || Y_INDEX !== 3'd0 || Y_OUT_ENABLE !== 1'b0
                    || W_IN_READY !== 1'b0 || X_IN_READY !== 1'b0)
                    $display("FAIL %s post_reset: READY=%b Y_OUT=%0d Y_INDEX=%0d EN=%b, required 1/0/0/0",
                             name, READY, Y_OUT, Y_INDEX, Y_OUT_ENABLE);
                else passes++;
            end
            if (Y_OUT_ENABLE === 1'b1) begin
                if (pulses < exp_y.size()) begin
                    checks++;
                    if (Y_OUT !== exp_y[pulses])
                        $display("FAIL %s y_out[%0d]: got %0d, required %0d",
                                 name, pulses, $signed(Y_OUT), $signed(exp_y[pulses]));
                    else passes++;
                    checks++;
                    if (Y_INDEX !== 3'(pulses))
                        $display("FAIL %s y_index[%0d]: got %0d, required %0d",
                                 name, pulses, Y_INDEX, pulses);
                    else passes++;
                    checks++;
                    if (n != (K + 1) * (pulses + 1))
                        $display("FAIL %s cadence[%0d]: pulse at cycle %0d, required %0d",
                                 name, pulses, n, (K + 1) * (pulses + 1));
                    else passes++;
                end
                pulses++;
            end
            @(negedge clk); n++;
        end
        RST = 1'b0;
        checks++;
        if (pulses != exp_cnt)
            $display("FAIL %s pulse_count: got %0d, required %0d", name, pulses, exp_cnt);
        else passes++;
        checks++;
        if (READY !== 1'b1) $display("FAIL %s ready_after: got %b, required 1", name, READY);
        else passes++;
        if (rst_at == 0 && exp_y.size() > 0) begin
            checks++;
            if (Y_OUT !== exp_y[exp_y.size() - 1] || Y_INDEX !== 3'(exp_y.size() - 1))
                $display("FAIL %s hold: Y_OUT=%0d Y_INDEX=%0d, required %0d/%0d", name,
                         $signed(Y_OUT), Y_INDEX, $signed(exp_y[exp_y.size() - 1]),
                         exp_y.size() - 1);
            else passes++;
        end
    endtask

    task automatic test_reset;
        RST = 1'b1;
        repeat (3) begin
            @(negedge clk);
            START = 1'($urandom_range(0, 1));
            W_IN_ENABLE = 1'($urandom_range(0, 1));
            X_IN_ENABLE = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        checks++;
        if (READY !== 1'b1 || W_IN_READY !== 1'b0 || X_IN_READY !== 1'b0)
            $display("FAIL reset ready: READY=%b W=%b X=%b, required 1/0/0", READY, W_IN_READY, X_IN_READY);
        else passes++;
        checks++;
        if (Y_OUT_ENABLE !== 1'b0 || Y_OUT !== '0 || Y_INDEX !== 3'd0)
            $display("FAIL reset outputs: EN=%b Y_OUT=%0d Y_INDEX=%0d, required 0/0/0",
                     Y_OUT_ENABLE, Y_OUT, Y_INDEX);
        else passes++;
        START = 1'b0; W_IN_ENABLE = 1'b0; X_IN_ENABLE = 1'b0;
        RST = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_valid;
        set_ramp_data(1, 2, 3);
        exp_y = '{64'd14, 64'd20, 64'd26, 64'd32, 64'd38, 64'd44};
        run_job("valid", 1'b0, 0, 1'b0, 1'b0, 1'b0, 0);
    endtask

    task automatic test_same;
        set_ramp_data(1, 2, 3);
        exp_y = '{64'd13, 64'd19, 64'd25, 64'd31, 64'd37, 64'd43, 64'd49, 64'd28};
        run_job("same", 1'b1, 5, 1'b0, 1'b0, 1'b0, 0);
    endtask

    task automatic test_stall;
        set_ramp_data(1, 2, 3);
        exp_y = '{64'd14, 64'd20, 64'd26, 64'd32, 64'd38, 64'd44};
        run_job("stall", 1'b0, 0, 1'b1, 1'b1, 1'b0, 0);
    endtask

    task automatic test_relu;
        set_ramp_data('1, 0, 0);
        build_expected(1'b0, 0);
        run_job("relu", 1'b0, 0, 1'b0, 1'b0, 1'b0, 0);
    endtask

    task automatic test_reset_mid_mac;
        set_ramp_data(1, 2, 3);
        build_expected(1'b0, 0);
        run_job("reset_mid_mac", 1'b0, 0, 1'b0, 1'b0, 1'b0, K + 1 + 2);
        build_expected(1'b0, 0);
        run_job("after_reset", 1'b0, 0, 1'b0, 1'b0, 1'b0, 0);
    endtask

    task automatic test_start_in_load_x;
        set_ramp_data(1, 2, 3);
        build_expected(1'b0, 0);
        run_job("start_in_x", 1'b0, 0, 1'b0, 1'b0, 1'b1, 0);
    endtask

    task automatic test_wrap;
        mw[0] = 64'h8000_0000_0000_0000;
        mw[1] = 64'h8000_0000_0000_0000;
        mw[2] = 64'h8000_0000_0000_0000;
        for (int i = 0; i < X; i++) mx[i] = 2;
        exp_y = '{64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0};
        run_job("wrap", 1'b0, 0, 1'b0, 1'b0, 1'b0, 0);
    endtask

    task automatic test_random;
        for (int r = 0; r < 4; r++) begin
            bit m;
            logic [D-1:0] b;
            m = 1'($urandom_range(0, 1));
            b = {$urandom, $urandom};
            for (int k = 0; k < K; k++) mw[k] = {$urandom, $urandom};
            for (int i = 0; i < X; i++) mx[i] = {$urandom, $urandom};
            build_expected(m, b);
            run_job("random", m, b, 1'b1, 1'b1, 1'b0, 0);
        end
    endtask

    task automatic test_back_to_back;
        for (int r = 0; r < 2; r++) begin
            bit m;
            m = r[0];
            for (int k = 0; k < K; k++) mw[k] = D'($urandom_range(0, 50)) - 25;
            for (int i = 0; i < X; i++) mx[i] = D'($urandom_range(0, 50)) - 25;
            build_expected(m, 7);
            run_job("back_to_back", m, 7, 1'b0, 1'b0, 1'b0, 0);
        end
    endtask

    initial begin
        test_reset;
        test_valid;
        test_same;
        test_stall;
        test_relu;
        test_reset_mid_mac;
        test_start_in_load_x;
        test_wrap;
        test_random;
        test_back_to_back;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/accelerator_convolutional_fnn_engine.md
Name: accelerator_convolutional_fnn_engine

Overview:
- Parametrised 1-D convolution engine for the convolutional FNN accelerator: loads K_SIZE weights and an X_SIZE input vector, then streams out bias + weighted-window sums.
- Adds runtime VALID/SAME padding and K-tap MAC sequencing on top of the fixed system sizes in the shared package.
- Sits between the NTM controller's data movers and the FNN output stage.

Parameters:
- DATA_SIZE, 64, word width of weights, samples, bias and outputs (two's complement).
- X_SIZE, 64, input vector length; must be ≥ K_SIZE (elaboration error otherwise).
- K_SIZE, 3, number of kernel taps; must be ≥ 1.

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous, active-high reset
- START  in  1  one-cycle start pulse; honoured only in IDLE
- MODE  in  1  padding mode, sampled at START; 0 = VALID, 1 = SAME
- B_IN  in  DATA_SIZE  bias, sampled at START
- W_IN_ENABLE  in  1  weight valid
- W_IN  in  DATA_SIZE  weight word
- W_IN_READY  out  1  engine accepts a weight
- X_IN_ENABLE  in  1  sample valid
- X_IN  in  DATA_SIZE  sample word
- X_IN_READY  out  1  engine accepts a sample
- Y_OUT_ENABLE  out  1  one-cycle output-valid pulse
- Y_OUT  out  DATA_SIZE  output word
- Y_INDEX  out  $clog2(X_SIZE)  index t of Y_OUT
- READY  out  1  high while IDLE

Behaviour:
- Single clock CLK. Reset is synchronous and active-high on RST.
- Reset values: READY=1, W_IN_READY=0, X_IN_READY=0, Y_OUT_ENABLE=0, Y_OUT=0, Y_INDEX=0. State returns to IDLE and all counters clear.
- RST overrides everything, including mid-load or mid-compute; partial results are discarded and no further Y_OUT_ENABLE pulses are produced.
- FSM states: IDLE, LOAD_W, LOAD_X, MAC, EMIT.
- IDLE: READY=1. On START, latch MODE and B_IN and go to LOAD_W. START outside IDLE is ignored.
- LOAD_W: W_IN_READY=1. A weight is accepted when W_IN_ENABLE=1 and stores to w[wcnt], then wcnt increments. After weight K_SIZE-1 is accepted, go to LOAD_X. Gaps in W_IN_ENABLE are allowed.
- LOAD_X: X_IN_READY=1. A sample is accepted when X_IN_ENABLE=1 and stores to x[xcnt]. After sample X_SIZE-1 is accepted, go to MAC with t=0, k=0, and acc=bias.
- Enables arriving while the corresponding READY is low are ignored. This includes X_IN_ENABLE during LOAD_W.
- MAC: one tap per cycle, acc += w[k]*xp(t+k), for k = 0..K_SIZE-1. After k=K_SIZE-1, go to EMIT.
- Padded sample xp(i):
  - VALID mode: xp(i) = x[i].
  - SAME mode: xp(i) = x[i-P] with P = floor((K_SIZE-1)/2), and xp(i) = 0 when i-P lies outside [0, X_SIZE-1].
- Arithmetic: the product is truncated to its low DATA_SIZE bits. Accumulation wraps modulo 2^DATA_SIZE. There is no saturation.
- EMIT (one cycle): Y_OUT_ENABLE=1, Y_OUT=acc (post-feature), Y_INDEX=t.
  - If t equals T_LAST, go to IDLE; READY rises the next cycle.
  - Otherwise increment t, set k=0, acc=bias, and return to MAC.
  - T_LAST = X_SIZE-K_SIZE in VALID mode, X_SIZE-1 in SAME mode.
- Cadence: one output every K_SIZE+1 cycles. The first Y_OUT_ENABLE occurs K_SIZE+1 cycles after the last sample is accepted.
- Y_OUT and Y_INDEX hold their last values between pulses.
- Boundary case: with K_SIZE = X_SIZE in VALID mode, exactly one output is produced (t=0).

Optional Feature:
- Macro: ACCELERATOR_CONVOLUTIONAL_FNN_RELU_EN.
- Defined: in EMIT, Y_OUT = 0 when acc is negative (MSB=1), otherwise acc.
- Undefined: Y_OUT = acc unmodified. Timing is identical in both builds.

Decomposition:
- Shared package accelerator_convolutional_fnn_pkg holds:
  - DATA_SIZE, CONTROL_SIZE, X/Y/N/W/L/R;
  - new constant K_SIZE;
  - enum typedef for the FSM states;
  - MODE_VALID=0 and MODE_SAME=1 constants.
- One sub-module is natural: accelerator_convolutional_fnn_mac. It is a registered multiply-accumulate with clear-to-bias and truncation rules, instantiated once.

Test Plan:
- VALID mode: K=3, X=8, w={1,2,3}, x=1..8, b=0 → 6 pulses with Y_INDEX 0..5 and Y_OUT = 14,20,26,32,38,44; READY high after the last pulse.
- SAME mode: same data, b=5 → 8 pulses with Y_OUT = 13,19,25,31,37,43,49,28.
- Stalled loads: random gaps on W_IN_ENABLE and X_IN_ENABLE, plus X_IN_ENABLE asserted during LOAD_W (ignored) → outputs identical to the VALID-mode case.
- ReLU: w={-1,0,0}, x=1..8, VALID mode.
  - With ACCELERATOR_CONVOLUTIONAL_FNN_RELU_EN: six outputs of 0.
  - Without it: -1,-2,-3,-4,-5,-6.
- Reset mid-MAC: RST asserted on the 2nd output's MAC cycle → no further pulses and all outputs at reset values. A new START with VALID-mode data then reproduces 14..44.
- START pulsed during LOAD_X → ignored. Wrap-around: w=2^(DATA_SIZE-1), x all 2, b=0 → Y_OUT=0 for every t.
